// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues cache requests and queues {instruction, PC} pairs for decode.
// Optional JAL next-PC prediction is built when FETCH_JAL_PREDICT_EN is defined.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    output logic                     fetch_valid_out,
    output logic [ADDR_W-1:0]        fetch_addr_out,
    input  logic                     resp_valid_in,
    input  logic [INST_W-1:0]        mem_inst_in,
    input  logic                     redirect_in,
    input  logic [ADDR_W-1:0]        redirect_pc_in,
    input  logic                     deq_in,
    output logic                     inst_valid_out,
    output logic [INST_W-1:0]        inst_out,
    output logic [ADDR_W-1:0]        inst_pc_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic               fetch_valid_r;
    logic [ADDR_W-1:0]  fetch_addr_r;
    logic [INST_W-1:0]  inst_mem_r [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_r   [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic               enq_s;
    logic               deq_s;
    logic               flush_s;
    logic [ADDR_W-1:0]  resp_next_pc_s;

`ifdef FETCH_JAL_PREDICT_EN
    // Sign-extended J-type immediate of a JAL word.
    function automatic logic [ADDR_W-1:0] jal_imm_f(input logic [INST_W-1:0] inst);
        return {{(ADDR_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
`endif

    // Next fetch PC after an accepted response.
    always_comb begin
        resp_next_pc_s = fetch_addr_r + ADDR_W'(32'd4);
`ifdef FETCH_JAL_PREDICT_EN
        if (mem_inst_in[6:0] == 7'b1101111) begin
            resp_next_pc_s = fetch_addr_r + jal_imm_f(mem_inst_in);
        end else begin
            resp_next_pc_s = fetch_addr_r + ADDR_W'(32'd4);
        end
`endif
    end

    // FIFO control: redirect flushes and suppresses both enqueue and dequeue.
    always_comb begin
        enq_s   = 1'b0;
        deq_s   = 1'b0;
        flush_s = 1'b0;
        if (rdy_in) begin
            flush_s = redirect_in;
            enq_s   = ~redirect_in & resp_valid_in & (state_r == ST_WAIT);
            deq_s   = ~redirect_in & deq_in & (count_r != '0);
        end else begin
            flush_s = 1'b0;
            enq_s   = 1'b0;
            deq_s   = 1'b0;
        end
    end

    // Fetch request state machine; the cache cannot abort, so a redirected request drains in DISCARD.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            fetch_valid_r <= 1'b0;
            fetch_addr_r  <= RESET_PC;
        end else if (rdy_in) begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_in) begin
                        pc_r <= redirect_pc_in;
                    end else if (count_r < CNT_W'(DEPTH)) begin
                        fetch_valid_r <= 1'b1;
                        fetch_addr_r  <= pc_r;
                        state_r       <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (redirect_in) begin
                        pc_r <= redirect_pc_in;
                        if (resp_valid_in) begin
                            fetch_valid_r <= 1'b0;
                            state_r       <= ST_IDLE;
                        end else begin
                            state_r <= ST_DISCARD;
                        end
                    end else if (resp_valid_in) begin
                        pc_r          <= resp_next_pc_s;
                        fetch_valid_r <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (redirect_in) begin
                        pc_r <= redirect_pc_in;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (resp_valid_in) begin
                        fetch_valid_r <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    fetch_valid_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Circular FIFO storage and occupancy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= '0;
                pc_mem_r[i]   <= '0;
            end
        end else if (flush_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq_s) begin
                inst_mem_r[tail_r] <= mem_inst_in;
                pc_mem_r[tail_r]   <= fetch_addr_r;
                tail_r             <= tail_r + PTR_W'(1'b1);
            end else begin
                tail_r <= tail_r;
            end
            if (deq_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; reads zero while the queue is empty.
    always_comb begin
        if (count_r != '0) begin
            inst_out    = inst_mem_r[head_r];
            inst_pc_out = pc_mem_r[head_r];
        end else begin
            inst_out    = '0;
            inst_pc_out = '0;
        end
    end

    assign fetch_valid_out = fetch_valid_r;
    assign fetch_addr_out  = fetch_addr_r;
    assign inst_valid_out  = (count_r != '0);
    assign count_out       = count_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a scoreboard queue of expected {inst, pc} entries is
// checked by a monitor on every accepted dequeue; control outputs are checked inline.
module tb_inst_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        fetch_valid_out;
    logic [31:0] fetch_addr_out;
    logic        resp_valid_in = 1'b0;
    logic [31:0] mem_inst_in = 32'd0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'd0;
    logic        deq_in = 1'b0;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic [2:0]  count_out;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];

    inst_fetch_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .fetch_valid_out(fetch_valid_out), .fetch_addr_out(fetch_addr_out),
        .resp_valid_in(resp_valid_in), .mem_inst_in(mem_inst_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .deq_in(deq_in), .inst_valid_out(inst_valid_out), .inst_out(inst_out),
        .inst_pc_out(inst_pc_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; resp_valid_in = 1'b0; redirect_in = 1'b0; deq_in = 1'b0;
        exp_q.delete();
        step(); step();
        rst_n_in = 1'b1;
    endtask

    task automatic wait_req(input int maxc);
        int n = 0;
        while (!fetch_valid_out && n < maxc) begin
            step();
            n++;
        end
        check("req_seen", {31'd0, fetch_valid_out}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] word, input bit push);
        resp_valid_in = 1'b1;
        mem_inst_in = word;
        if (push) exp_q.push_back({word, fetch_addr_out});
        step();
        resp_valid_in = 1'b0;
        mem_inst_in = 32'd0;
    endtask

    // Scoreboard monitor: samples inputs and head between the drive point and the next rising edge.
    initial begin
        logic [63:0] item;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_n_in && rdy_in) begin
                if (redirect_in) begin
                    exp_q.delete();
                end else if (deq_in && inst_valid_out) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_underflow: got pc %0h expected no entry", inst_pc_out);
                    end else begin
                        item = exp_q.pop_front();
                        check("head_inst", inst_out, item[63:32]);
                        check("head_pc", inst_pc_out, item[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        step();
        check("rst_fv", {31'd0, fetch_valid_out}, 32'd0);
        check("rst_addr", fetch_addr_out, 32'd0);
        check("rst_cnt", {29'd0, count_out}, 32'd0);
        check("rst_ivalid", {31'd0, inst_valid_out}, 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_ipc", inst_pc_out, 32'd0);
        do_reset();

        // Fill to full, then one dequeue reopens fetch at 16
        for (int i = 0; i < 4; i++) begin
            wait_req(4);
            check("fill_addr", fetch_addr_out, 32'(4 * i));
            respond(32'h00000013, 1'b1);
        end
        check("full_cnt", {29'd0, count_out}, 32'd4);
        check("full_head", inst_pc_out, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_nofetch", {31'd0, fetch_valid_out}, 32'd0);
        end
        deq_in = 1'b1; step(); deq_in = 1'b0;
        wait_req(2);
        check("reopen_addr", fetch_addr_out, 32'd16);
        respond(32'h00000013, 1'b1);
        deq_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        deq_in = 1'b0;

        // Redirect while waiting for address 8; response arrives 3 cycles later
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_req(4);
            respond(32'h11110000 + 32'(i), 1'b1);
        end
        wait_req(4);
        check("wait8_addr", fetch_addr_out, 32'd8);
        redirect_in = 1'b1; redirect_pc_in = 32'h100;
        step();
        redirect_in = 1'b0;
        check("redir_cnt", {29'd0, count_out}, 32'd0);
        check("redir_ivalid", {31'd0, inst_valid_out}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("discard_fv", {31'd0, fetch_valid_out}, 32'd1);
            check("discard_addr", fetch_addr_out, 32'd8);
            step();
        end
        respond(32'hDEADBEEF, 1'b0);
        check("dropped_cnt", {29'd0, count_out}, 32'd0);
        wait_req(4);
        check("redir_addr", fetch_addr_out, 32'h100);
        respond(32'hAAAA5555, 1'b1);
        check("redir_enq_cnt", {29'd0, count_out}, 32'd1);
        deq_in = 1'b1; step(); deq_in = 1'b0;

        // Redirect + response + dequeue in one cycle, 2 entries queued
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_req(4);
            respond(32'h22220000 + 32'(i), 1'b1);
        end
        wait_req(4);
        redirect_in = 1'b1; redirect_pc_in = 32'h200; deq_in = 1'b1;
        respond(32'hBADBAD00, 1'b0);
        redirect_in = 1'b0; deq_in = 1'b0;
        check("triple_cnt", {29'd0, count_out}, 32'd0);
        check("triple_fv", {31'd0, fetch_valid_out}, 32'd0);
        deq_in = 1'b1; step(); deq_in = 1'b0;
        check("empty_deq_cnt", {29'd0, count_out}, 32'd0);
        wait_req(4);
        check("triple_addr", fetch_addr_out, 32'h200);

        // Simultaneous enqueue and dequeue at count 2 across 10 fills
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_req(4);
            respond(32'h33330000 + 32'(i), 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            wait_req(4);
            check("ed_cnt_before", {29'd0, count_out}, 32'd2);
            deq_in = 1'b1;
            respond(32'h44440000 + 32'(k), 1'b1);
            deq_in = 1'b0;
            check("ed_cnt_after", {29'd0, count_out}, 32'd2);
            check("ed_head_pc", inst_pc_out, 32'(4 * k + 4));
        end

        // Pause mid-WAIT, then asynchronous reset mid-WAIT
        do_reset();
        wait_req(4);
        respond(32'h55550000, 1'b1);
        wait_req(4);
        rdy_in = 1'b0; deq_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h300;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pause_fv", {31'd0, fetch_valid_out}, 32'd1);
            check("pause_addr", fetch_addr_out, 32'd4);
            check("pause_cnt", {29'd0, count_out}, 32'd1);
            check("pause_head", inst_pc_out, 32'd0);
        end
        rdy_in = 1'b1; deq_in = 1'b0; redirect_in = 1'b0;
        respond(32'h55550001, 1'b1);
        check("resume_cnt", {29'd0, count_out}, 32'd2);
        wait_req(4);
        check("resume_addr", fetch_addr_out, 32'd8);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_fv", {31'd0, fetch_valid_out}, 32'd0);
        check("arst_addr", fetch_addr_out, 32'd0);
        check("arst_cnt", {29'd0, count_out}, 32'd0);
        check("arst_ipc", inst_pc_out, 32'd0);
        exp_q.delete();
        step();
        rst_n_in = 1'b1;

        // JAL word at 0x20
        redirect_in = 1'b1; redirect_pc_in = 32'h20;
        step();
        redirect_in = 1'b0;
        wait_req(4);
        check("jal_src_addr", fetch_addr_out, 32'h20);
        respond(32'h0100006F, 1'b1);
        wait_req(4);
`ifdef FETCH_JAL_PREDICT_EN
        check("jal_next_addr", fetch_addr_out, 32'h30);
`else
        check("jal_next_addr", fetch_addr_out, 32'h24);
`endif

        // PC wrap from all-ones-minus-3
        do_reset();
        redirect_in = 1'b1; redirect_pc_in = 32'hFFFFFFFC;
        step();
        redirect_in = 1'b0;
        wait_req(4);
        check("wrap_src_addr", fetch_addr_out, 32'hFFFFFFFC);
        respond(32'h00000013, 1'b1);
        wait_req(4);
        check("wrap_addr", fetch_addr_out, 32'd0);
        deq_in = 1'b1; step(); deq_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
